// File: rtl/intf_param_fifo_if.sv
// rtl/intf_param_fifo_if.sv - stream_if bundle carrying width/depth parameters to the FIFO
interface stream_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  function automatic int getWidth();
    return WIDTH;
  endfunction

  function automatic int getDepth();
    return DEPTH;
  endfunction

  modport sink (
    import getWidth,
    import getDepth,
    input  valid,
    input  data,
    output ready
  );

  modport source (
    import getWidth,
    import getDepth,
    output valid,
    output data,
    input  ready
  );
endinterface

// File: rtl/intf_param_fifo.sv
// rtl/intf_param_fifo.sv - synchronous FIFO sized by the parameters of its stream_if ports
module intf_param_fifo #(
  parameter int AF_LEVEL = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  stream_if.sink                           in_if,
  stream_if.source                         out_if,
  output logic [$clog2(in_if.DEPTH+1)-1:0] count,
  output logic                             almost_full
);
  localparam int W  = in_if.WIDTH;
  localparam int D  = in_if.DEPTH;
  localparam int AF = (AF_LEVEL == 0) ? D - 1 : AF_LEVEL;
  localparam int CW = $clog2(D + 1);
  localparam int PW = (D > 1) ? $clog2(D) : 1;

  generate
    if (out_if.WIDTH != W) begin : g_err_width
      $error("intf_param_fifo: out_if.WIDTH differs from in_if.WIDTH");
    end
    if (D < 1) begin : g_err_depth
      $error("intf_param_fifo: DEPTH must be at least 1");
    end
    if (AF > D) begin : g_err_af
      $error("intf_param_fifo: almost-full level exceeds DEPTH");
    end
  endgenerate

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign in_if.ready  = (count != CW'(D));
  assign out_if.valid = (count != '0);
  assign out_if.data  = mem[rd_ptr];
  assign almost_full  = (count >= CW'(AF));

  assign push = in_if.valid && in_if.ready;
  assign pop  = out_if.valid && out_if.ready;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_if.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (count <= CW'(D));
    end
  end
endmodule

// File: tb/tb_intf_param_fifo.sv
// tb/tb_intf_param_fifo.sv - self-checking bench for intf_param_fifo (D=5 and D=1 instances)
module tb_intf_param_fifo;
  logic clk;
  logic rst_n;

  stream_if #(.WIDTH(12), .DEPTH(5)) in5 ();
  stream_if #(.WIDTH(12), .DEPTH(5)) out5 ();
  stream_if #(.WIDTH(8),  .DEPTH(1)) in1 ();
  stream_if #(.WIDTH(8),  .DEPTH(1)) out1 ();

  logic [2:0] count5;
  logic       af5;
  logic [0:0] count1;
  logic       af1;

  intf_param_fifo u5 (
    .clk(clk), .rst_n(rst_n), .in_if(in5.sink), .out_if(out5.source),
    .count(count5), .almost_full(af5)
  );

  intf_param_fifo #(.AF_LEVEL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_if(in1.sink), .out_if(out1.source),
    .count(count1), .almost_full(af1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [11:0] q5[$];
  logic [7:0]  q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle on the D=5 instance, compare against the queue model mid-cycle,
  // then apply the handshake rules to the model at the clock edge.
  task automatic cyc5(input bit v, input logic [11:0] d, input bit r);
    bit mp, mq;
    in5.valid  = v;
    in5.data   = d;
    out5.ready = r;
    #4;
    check("ready5", 32'(in5.ready), 32'(q5.size() != 5));
    check("valid5", 32'(out5.valid), 32'(q5.size() != 0));
    check("count5", 32'(count5), 32'(q5.size()));
    check("af5", 32'(af5), 32'(q5.size() >= 4));
    if (q5.size() > 0) check("data5", 32'(out5.data), 32'(q5[0]));
    mp = v && (q5.size() < 5);
    mq = r && (q5.size() > 0);
    @(posedge clk);
    if (mq) void'(q5.pop_front());
    if (mp) q5.push_back(d);
    #1;
  endtask

  task automatic cyc1(input bit v, input logic [7:0] d, input bit r, output bit pushed);
    bit mq;
    in1.valid  = v;
    in1.data   = d;
    out1.ready = r;
    #4;
    check("ready1", 32'(in1.ready), 32'(q1.size() == 0));
    check("valid1", 32'(out1.valid), 32'(q1.size() != 0));
    check("count1", 32'(count1), 32'(q1.size()));
    check("af1", 32'(af1), 32'(q1.size() >= 1));
    if (q1.size() > 0) check("data1", 32'(out1.data), 32'(q1[0]));
    pushed = v && (q1.size() == 0);
    mq = r && (q1.size() > 0);
    @(posedge clk);
    if (mq) void'(q1.pop_front());
    if (pushed) q1.push_back(d);
    #1;
  endtask

  typedef struct {
    bit          v;
    logic [11:0] d;
    bit          r;
    bit          e_ready;
    bit          e_valid;
    logic [2:0]  e_count;
    bit          e_af;
    logic [11:0] e_data;
  } vec_t;

  vec_t vecs[12];
  bit   pushed;
  int   accepted;

  initial begin
    // Fill 1..5 with ready low, attempt a sixth, then drain; expectations are post-edge.
    vecs[0]  = '{1, 12'h001, 0, 1, 1, 3'd1, 0, 12'h001};
    vecs[1]  = '{1, 12'h002, 0, 1, 1, 3'd2, 0, 12'h001};
    vecs[2]  = '{1, 12'h003, 0, 1, 1, 3'd3, 0, 12'h001};
    vecs[3]  = '{1, 12'h004, 0, 1, 1, 3'd4, 1, 12'h001};
    vecs[4]  = '{1, 12'h005, 0, 0, 1, 3'd5, 1, 12'h001};
    vecs[5]  = '{1, 12'h006, 0, 0, 1, 3'd5, 1, 12'h001};
    vecs[6]  = '{0, 12'h000, 1, 1, 1, 3'd4, 1, 12'h002};
    vecs[7]  = '{0, 12'h000, 1, 1, 1, 3'd3, 0, 12'h003};
    vecs[8]  = '{0, 12'h000, 1, 1, 1, 3'd2, 0, 12'h004};
    vecs[9]  = '{0, 12'h000, 1, 1, 1, 3'd1, 0, 12'h005};
    vecs[10] = '{0, 12'h000, 1, 1, 0, 3'd0, 0, 12'h000};
    vecs[11] = '{0, 12'h000, 0, 1, 0, 3'd0, 0, 12'h000};

    in5.valid = 0; in5.data = '0; out5.ready = 0;
    in1.valid = 0; in1.data = '0; out1.ready = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;

    check("elab_getWidth", 32'(in5.getWidth()), 32'd12);
    check("elab_getDepth", 32'(in5.getDepth()), 32'd5);
    check("elab_W", 32'(u5.W), 32'd12);
    check("elab_D", 32'(u5.D), 32'd5);
    check("elab_count_bits", 32'($bits(count5)), 32'd3);

    check("rst_count5", 32'(count5), 32'd0);
    check("rst_valid5", 32'(out5.valid), 32'd0);
    check("rst_ready5", 32'(in5.ready), 32'd1);
    check("rst_af5", 32'(af5), 32'd0);
    check("rst_ready1", 32'(in1.ready), 32'd1);
    check("rst_af1", 32'(af1), 32'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      cyc5(vecs[i].v, vecs[i].d, vecs[i].r);
      check($sformatf("vec%0d_ready", i), 32'(in5.ready), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d_valid", i), 32'(out5.valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_count", i), 32'(count5), 32'(vecs[i].e_count));
      check($sformatf("vec%0d_af", i), 32'(af5), 32'(vecs[i].e_af));
      if (vecs[i].e_valid) check($sformatf("vec%0d_data", i), 32'(out5.data), 32'(vecs[i].e_data));
    end

    // Wrap-around: hold occupancy at 1 while streaming 23 beats through.
    cyc5(1, 12'h100, 0);
    for (int i = 1; i <= 23; i++) begin
      cyc5(1, 12'(12'h100 + i), 1);
      check("wrap_count", 32'(count5), 32'd1);
    end
    check("wrap_last", 32'(out5.data), 32'h117);
    cyc5(0, 12'h000, 1);

    // Full with push and pop requested: only the pop happens.
    for (int i = 0; i < 5; i++) cyc5(1, 12'(12'h200 + i), 0);
    check("full_count", 32'(count5), 32'd5);
    cyc5(1, 12'h7AA, 1);
    check("full_pop_count", 32'(count5), 32'd4);
    check("full_pop_ready", 32'(in5.ready), 32'd1);
    for (int i = 0; i < 4; i++) cyc5(0, 12'h000, 1);
    check("full_pop_empty", 32'(out5.valid), 32'd0);

    // Empty with push and ready high: no fall-through.
    in5.valid = 1; in5.data = 12'h3C3; out5.ready = 1;
    #4;
    check("empty_push_valid_now", 32'(out5.valid), 32'd0);
    @(posedge clk);
    q5.push_back(12'h3C3);
    #1;
    check("empty_push_valid_next", 32'(out5.valid), 32'd1);
    check("empty_push_data_next", 32'(out5.data), 32'h3C3);
    cyc5(0, 12'h000, 1);

    // Asynchronous reset between edges after three pushes.
    for (int i = 0; i < 3; i++) cyc5(1, 12'(12'h050 + i), 0);
    in5.valid = 0;
    rst_n = 1'b0;
    #2;
    check("arst_count", 32'(count5), 32'd0);
    check("arst_valid", 32'(out5.valid), 32'd0);
    check("arst_ready", 32'(in5.ready), 32'd1);
    rst_n = 1'b1;
    q5.delete();
    q1.delete();
    @(posedge clk);
    #1;
    cyc5(1, 12'hABC, 0);
    check("arst_first_data", 32'(out5.data), 32'hABC);
    cyc5(1, 12'hDEF, 0);
    check("arst_first_data_hold", 32'(out5.data), 32'hABC);
    cyc5(0, 12'h000, 1);
    cyc5(0, 12'h000, 1);

    // Randomised traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      cyc5(1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 3) != 0 || i > 380));
    end

    // Depth-1 instance.
    cyc1(1, 8'h5A, 0, pushed);
    check("d1_count", 32'(count1), 32'd1);
    check("d1_af", 32'(af1), 32'd1);
    check("d1_ready", 32'(in1.ready), 32'd0);
    check("d1_data", 32'(out1.data), 32'h5A);
    cyc1(0, 8'h00, 1, pushed);
    check("d1_pop_count", 32'(count1), 32'd0);
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      cyc1(1, 8'(8'h10 + i), 1, pushed);
      if (pushed) accepted++;
    end
    check("d1_throughput", 32'(accepted), 32'd5);
    cyc1(0, 8'h00, 1, pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
